// File: rtl/fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_prog
//  Description : Single-clock FIFO with runtime-programmable almost-full /
//                almost-empty thresholds, sticky overflow/underflow flags and
//                selectable show-ahead or normal read mode.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_prog #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int SHOWAHEAD = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic [AWIDTH:0]   af_thr_i,
  input  logic [AWIDTH:0]   ae_thr_i,
  input  logic              clr_err_i,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);

  // Storage array; contents are never reset, only pointers and count are.
  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              access_en;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Status decode and access qualification from the registered count.
  always_comb begin
    access_en = rst_sync_q[1];
    full      = (usedw_q == DEPTH_CNT);
    empty     = (usedw_q == '0);
    wr_acc    = wrreq_i & ~full & access_en;
    rd_acc    = rdreq_i & ~empty & access_en;
  end

  // Next-state for pointers, count, error flags and reset synchroniser.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    usedw_d    = usedw_q;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase
    // A new error event in the same cycle as a clear keeps the flag set.
    ovf_d = (wrreq_i & full)  | (ovf_q & ~clr_err_i);
    udf_d = (rdreq_i & empty) | (udf_q & ~clr_err_i);
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Keep q_q loaded with the head word; bypass data_i when the new head
      // is the location being written at this same edge.
      always_comb begin
        q_d = q_q;
        if ((rd_acc || empty) && (usedw_d != '0)) begin
          if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            q_d = data_i;
          end else begin
            q_d = mem_q[rd_ptr_d];
          end
        end
      end
    end else begin : g_normal
      // Load the word being read; hold otherwise.
      always_comb begin
        q_d = q_q;
        if (rd_acc) begin
          q_d = mem_q[rd_ptr_q];
        end
      end
    end
  endgenerate

  // Memory write port.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rst_sync_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      q_q        <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usedw_q    <= usedw_d;
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Output mapping; threshold flags are combinational on the registered count.
  always_comb begin
    q_o            = q_q;
    usedw_o        = usedw_q;
    full_o         = full;
    empty_o        = empty;
    almost_full_o  = (usedw_q >= af_thr_i);
    almost_empty_o = (usedw_q <  ae_thr_i);
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_prog
//  Description : Directed table-driven bench for fifo_prog, with one
//                show-ahead and one normal-mode instance on shared inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_prog;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk_i    = 1'b0;
  logic          arst_n_i = 1'b0;
  logic [DW-1:0] data_i   = '0;
  logic          wrreq_i  = 1'b0;
  logic          rdreq_i  = 1'b0;
  logic [AW:0]   af_thr_i = 4'd6;
  logic [AW:0]   ae_thr_i = 4'd2;
  logic          clr_err_i = 1'b0;

  logic [DW-1:0] q_sa, q_nm;
  logic [AW:0]   usedw_sa, usedw_nm;
  logic          full_sa, empty_sa, af_sa, ae_sa, ovf_sa, udf_sa;
  logic          full_nm, empty_nm, af_nm, ae_nm, ovf_nm, udf_nm;

  fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1)) dut_sa (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .wrreq_i(wrreq_i),
    .rdreq_i(rdreq_i), .af_thr_i(af_thr_i), .ae_thr_i(ae_thr_i),
    .clr_err_i(clr_err_i), .q_o(q_sa), .usedw_o(usedw_sa), .full_o(full_sa),
    .empty_o(empty_sa), .almost_full_o(af_sa), .almost_empty_o(ae_sa),
    .overflow_o(ovf_sa), .underflow_o(udf_sa)
  );

  fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(0)) dut_nm (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .wrreq_i(wrreq_i),
    .rdreq_i(rdreq_i), .af_thr_i(af_thr_i), .ae_thr_i(ae_thr_i),
    .clr_err_i(clr_err_i), .q_o(q_nm), .usedw_o(usedw_nm), .full_o(full_nm),
    .empty_o(empty_nm), .almost_full_o(af_nm), .almost_empty_o(ae_nm),
    .overflow_o(ovf_nm), .underflow_o(udf_nm)
  );

  always #5 clk_i = ~clk_i;

  logic [9:0] st_sa, st_nm;
  assign st_sa = {usedw_sa, full_sa, empty_sa, af_sa, ae_sa, ovf_sa, udf_sa};
  assign st_nm = {usedw_nm, full_nm, empty_nm, af_nm, ae_nm, ovf_nm, udf_nm};

  typedef struct {
    logic        wr, rd, clr;
    logic [31:0] data;
    logic [3:0]  af, ae;
    logic [3:0]  usedw;
    logic        full, empty, afl, ael, ovf, udf;
    logic [31:0] q_sa, q_nm;
  } vec_t;

  vec_t tbl[64];
  int   n_tbl = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic wr, input logic rd, input logic clr,
                     input logic [31:0] data, input logic [3:0] af,
                     input logic [3:0] ae, input logic [3:0] usedw,
                     input logic full, input logic empty, input logic afl,
                     input logic ael, input logic ovf, input logic udf,
                     input logic [31:0] qsa, input logic [31:0] qnm);
    tbl[n_tbl].wr = wr;     tbl[n_tbl].rd = rd;       tbl[n_tbl].clr = clr;
    tbl[n_tbl].data = data; tbl[n_tbl].af = af;       tbl[n_tbl].ae = ae;
    tbl[n_tbl].usedw = usedw; tbl[n_tbl].full = full; tbl[n_tbl].empty = empty;
    tbl[n_tbl].afl = afl;   tbl[n_tbl].ael = ael;     tbl[n_tbl].ovf = ovf;
    tbl[n_tbl].udf = udf;   tbl[n_tbl].q_sa = qsa;    tbl[n_tbl].q_nm = qnm;
    n_tbl++;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Order of data after the first four reads: 5..8 then 100, 101, ...
  function automatic logic [31:0] stream(input int k);
    return (k < 4) ? 32'(5 + k) : 32'(96 + k);
  endfunction

  task automatic apply(input int idx);
    logic [9:0] exp_st;
    wrreq_i   = tbl[idx].wr;
    rdreq_i   = tbl[idx].rd;
    clr_err_i = tbl[idx].clr;
    data_i    = tbl[idx].data;
    af_thr_i  = tbl[idx].af;
    ae_thr_i  = tbl[idx].ae;
    @(posedge clk_i);
    #1;
    exp_st = {tbl[idx].usedw, tbl[idx].full, tbl[idx].empty, tbl[idx].afl,
              tbl[idx].ael, tbl[idx].ovf, tbl[idx].udf};
    chk("status_sa", idx, 32'(st_sa), 32'(exp_st));
    chk("status_nm", idx, 32'(st_nm), 32'(exp_st));
    chk("q_sa", idx, q_sa, tbl[idx].q_sa);
    chk("q_nm", idx, q_nm, tbl[idx].q_nm);
  endtask

  task automatic chk_reset_state(input int idx);
    // usedw=0, full=0, empty=1, af=0 (thr 6), ae=1 (thr 2), ovf=0, udf=0
    chk("rst_status_sa", idx, 32'(st_sa), 32'(10'b0000_0_1_0_1_0_0));
    chk("rst_status_nm", idx, 32'(st_nm), 32'(10'b0000_0_1_0_1_0_0));
    chk("rst_q_sa", idx, q_sa, 32'h0);
    chk("rst_q_nm", idx, q_nm, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++) begin
      add(1, 0, 0, 32'(i + 1), 6, 2, 4'(i + 1), (i == 7), 0, ((i + 1) >= 6),
          ((i + 1) < 2), 0, 0, 32'd1, 32'd0);
    end
    add(1, 0, 0, 32'd9,    6, 2, 8, 1, 0, 1, 0, 1, 0, 1, 0);   // write at full
    add(0, 0, 1, 32'd0,    6, 2, 8, 1, 0, 1, 0, 0, 0, 1, 0);   // clear
    add(1, 0, 1, 32'h99,   6, 2, 8, 1, 0, 1, 0, 1, 0, 1, 0);   // clear vs new error
    add(0, 0, 1, 32'd0,    6, 2, 8, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 32'h77,   6, 2, 7, 0, 0, 1, 0, 1, 0, 2, 1);   // rd+wr at full
    add(0, 0, 1, 32'd0,    6, 2, 7, 0, 0, 1, 0, 0, 0, 2, 1);
    add(0, 1, 0, 32'd0,    6, 2, 6, 0, 0, 1, 0, 0, 0, 3, 2);
    add(0, 1, 0, 32'd0,    6, 2, 5, 0, 0, 0, 0, 0, 0, 4, 3);
    add(0, 1, 0, 32'd0,    6, 2, 4, 0, 0, 0, 0, 0, 0, 5, 4);
    for (int k = 0; k < 20; k++) begin                          // rd+wr across wrap
      add(1, 1, 0, 32'(100 + k), 6, 2, 4, 0, 0, 0, 0, 0, 0, stream(k + 1), stream(k));
    end
    add(0, 1, 0, 32'd0,    6, 2, 3, 0, 0, 0, 0, 0, 0, 117, 116);
    add(0, 1, 0, 32'd0,    6, 2, 2, 0, 0, 0, 0, 0, 0, 118, 117);
    add(0, 1, 0, 32'd0,    6, 2, 1, 0, 0, 0, 1, 0, 0, 119, 118);
    add(0, 1, 0, 32'd0,    6, 2, 0, 0, 1, 0, 1, 0, 0, 119, 119);
    add(0, 1, 0, 32'd0,    6, 2, 0, 0, 1, 0, 1, 0, 1, 119, 119); // underflow
    add(1, 1, 0, 32'hA5,   6, 2, 1, 0, 0, 0, 1, 0, 1, 32'hA5, 119); // rd+wr at empty
    add(0, 0, 1, 32'd0,    6, 2, 1, 0, 0, 0, 1, 0, 0, 32'hA5, 119);
    add(0, 1, 0, 32'd0,    6, 2, 0, 0, 1, 0, 1, 0, 0, 32'hA5, 32'hA5);
    add(1, 0, 0, 32'h11,   6, 2, 1, 0, 0, 0, 1, 0, 0, 32'h11, 32'hA5);
    add(1, 1, 0, 32'h22,   6, 2, 1, 0, 0, 0, 1, 0, 0, 32'h22, 32'h11); // bypass at 1
    add(0, 1, 0, 32'd0,    6, 2, 0, 0, 1, 0, 1, 0, 0, 32'h22, 32'h22);
    add(0, 0, 0, 32'd0,    0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h22, 32'h22); // thresholds

    // ---------------- reset state ----------------
    #12;
    chk_reset_state(1000);
    arst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    for (int i = 0; i < n_tbl; i++) begin
      apply(i);
    end

    // ---------------- reset mid-burst ----------------
    af_thr_i = 4'd6;
    ae_thr_i = 4'd2;
    for (int i = 0; i < 5; i++) begin
      wrreq_i = 1'b1;
      data_i  = 32'h5000 + 32'(i);
      @(posedge clk_i);
      #1;
    end
    chk("burst_usedw", 2000, 32'(usedw_sa), 32'd5);
    data_i = 32'h5005;
    #2;
    arst_n_i = 1'b0;
    #1;
    chk_reset_state(2001);
    wrreq_i = 1'b0;
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b0;
    arst_n_i = 1'b1;
    wrreq_i  = 1'b1;
    data_i   = 32'hDEAD;
    @(posedge clk_i);
    #1;
    chk("sync_first_edge_usedw", 2002, 32'(usedw_sa), 32'd0);
    chk("sync_first_edge_empty", 2003, 32'(empty_nm), 32'd1);
    wrreq_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    wrreq_i = 1'b1;
    data_i  = 32'h6001;
    @(posedge clk_i);
    #1;
    chk("post_rst_usedw", 2004, 32'(usedw_sa), 32'd1);
    chk("post_rst_q_sa", 2005, q_sa, 32'h6001);
    wrreq_i = 1'b0;
    rdreq_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_q_nm", 2006, q_nm, 32'h6001);
    chk("post_rst_empty", 2007, 32'(empty_sa), 32'd1);
    rdreq_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
